// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state type, the bubble instruction
// and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDiscard
  } fetch_state_t;

  localparam logic [31:0] Nop            = 32'h0000_0000;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // Instruction addresses are word aligned; the low two bits are never honoured.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/flip_flop.sv
// Generic register with synchronous reset, synchronous clear and active-low enable.
module flip_flop #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_ni,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= ResetVal;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (!en_ni) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch-stage control: owns the PC, handshakes with the I-cache and presents the
// fetched instruction (or a NOP bubble) to the decode pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] ResetPc = DefaultResetPc
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_f_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ready_i,
  input  logic [31:0] icache_rdata_i,
  output logic [31:0] instr_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus_4_f_o,
  output logic        valid_f_o,
  output logic        miss_stall_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_inc;
  logic         pc_en;
  logic [31:0]  target_q, target_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  redirect_tgt;
  logic         req, valid, miss;
  logic [31:0]  instr;

  flip_flop #(
    .Width    (32),
    .ResetVal (ResetPc)
  ) u_pc_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_ni (~pc_en),
    .clr_i (1'b0),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  assign pc_inc       = pc_q + 32'd4;
  assign redirect_tgt = align_word(redirect_pc_i);

  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    pc_d     = pc_inc;
    target_d = target_q;
    buf_d    = buf_q;
    req      = 1'b0;
    valid    = 1'b0;
    miss     = 1'b0;
    instr    = Nop;

    unique case (state_q)
      StFetch: begin
        req = 1'b1;
        if (icache_ready_i) begin
          if (redirect_i) begin
            pc_en = 1'b1;
            pc_d  = redirect_tgt;
          end else begin
            valid = 1'b1;
            instr = icache_rdata_i;
            if (stall_f_i) begin
              buf_d   = icache_rdata_i;
              state_d = StHold;
            end else begin
              pc_en = 1'b1;
            end
          end
        end else if (redirect_i) begin
          // The cache cannot cancel, so the request keeps its address until answered.
          target_d = redirect_tgt;
          state_d  = StDiscard;
        end else begin
          miss = 1'b1;
        end
      end
      StHold: begin
        valid = 1'b1;
        instr = buf_q;
        if (redirect_i) begin
          pc_en   = 1'b1;
          pc_d    = redirect_tgt;
          state_d = StFetch;
        end else if (!stall_f_i) begin
          pc_en   = 1'b1;
          state_d = StFetch;
        end
      end
      StDiscard: begin
        req  = 1'b1;
        miss = 1'b1;
        if (redirect_i) begin
          target_d = redirect_tgt;
        end
        if (icache_ready_i) begin
          pc_en   = 1'b1;
          pc_d    = redirect_i ? redirect_tgt : target_q;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StFetch;
      target_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      buf_q    <= buf_d;
    end
  end

  // Quiet front end while reset is held; the outstanding request is abandoned.
  assign icache_req_o  = req & ~rst_i;
  assign valid_f_o     = valid & ~rst_i;
  assign miss_stall_o  = miss & ~rst_i;
  assign instr_f_o     = rst_i ? Nop : instr;
  assign icache_addr_o = pc_q;
  assign pc_f_o        = pc_q;
  assign pc_plus_4_f_o = pc_inc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, instr) pairs are queued as hits are
// driven and retired whenever decode would capture an instruction.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] pc_f;
  logic [31:0] pc4;
  logic        valid;
  logic        miss;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_f_i      (stall),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .icache_req_o   (req),
    .icache_addr_o  (addr),
    .icache_ready_i (ready),
    .icache_rdata_i (rdata),
    .instr_f_o      (instr),
    .pc_f_o         (pc_f),
    .pc_plus_4_f_o  (pc4),
    .valid_f_o      (valid),
    .miss_stall_o   (miss)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  // Decode captures an instruction whenever it is valid and fetch is not stalled.
  always @(negedge clk) begin
    if (valid && !stall && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", pc_f, instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (pc_f !== mon_e.pc || instr !== mon_e.instr || pc4 !== mon_e.pc + 32'd4) begin
          failures++;
          $display("FAIL sb_instr: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                   pc_f, instr, pc4, mon_e.pc, mon_e.instr, mon_e.pc + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] p);
    ready = 1'b1;
    rdata = mem(p);
    exp_q.push_back('{pc: p, instr: mem(p)});
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ready = 1'b1; rdata = mem(32'h0);
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || valid !== 1'b0 || miss !== 1'b0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b valid=%b miss=%b instr=%h, expected 0 0 0 0",
               req, valid, miss, instr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_hits();
    for (int i = 0; i < 4; i++) begin
      hit(32'(i * 4));
      @(negedge clk);
      checks++;
      if (addr !== 32'(i * 4) || valid !== 1'b1 || miss !== 1'b0) begin
        failures++;
        $display("FAIL hit_%0d: got addr=%h valid=%b miss=%b, expected addr=%h valid=1 miss=0",
                 i, addr, valid, miss, 32'(i * 4));
      end
      tick();
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 3; i++) begin
      ready = 1'b0; rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      checks++;
      if (miss !== 1'b1 || addr !== 32'h10 || instr !== 32'h0 || valid !== 1'b0 || req !== 1'b1) begin
        failures++;
        $display("FAIL miss_wait_%0d: got miss=%b addr=%h instr=%h valid=%b req=%b, expected 1 10 0 0 1",
                 i, miss, addr, instr, valid, req);
      end
      tick();
    end
    ready = 1'b1; rdata = 32'h2402_0001;
    exp_q.push_back('{pc: 32'h10, instr: 32'h2402_0001});
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || miss !== 1'b0) begin
      failures++;
      $display("FAIL miss_fill: got valid=%b miss=%b, expected valid=1 miss=0", valid, miss);
    end
    tick();
  endtask

  task automatic test_stall_hold();
    ready = 1'b1; stall = 1'b1; rdata = mem(32'h14);
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || instr !== mem(32'h14)) begin
      failures++;
      $display("FAIL stall_hit: got valid=%b instr=%h, expected 1 %h", valid, instr, mem(32'h14));
    end
    tick();
    ready = 1'b0; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || valid !== 1'b1 || instr !== mem(32'h14) || pc_f !== 32'h14) begin
      failures++;
      $display("FAIL hold: got req=%b valid=%b instr=%h pc=%h, expected 0 1 %h 14",
               req, valid, instr, pc_f, mem(32'h14));
    end
    tick();
    stall = 1'b0;
    exp_q.push_back('{pc: 32'h14, instr: mem(32'h14)});
    @(negedge clk);
    checks++;
    if (req !== 1'b0) begin
      failures++;
      $display("FAIL hold_release_req: got req=%b, expected 0", req);
    end
    tick();
    hit(32'h18);
    @(negedge clk);
    checks++;
    if (addr !== 32'h18 || req !== 1'b1) begin
      failures++;
      $display("FAIL after_hold_addr: got addr=%h req=%b, expected 18 1", addr, req);
    end
    tick();
  endtask

  task automatic test_redirect_discard();
    hit(32'h1C);
    tick();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40; rdata = 32'hBAD0_0001;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || miss !== 1'b0 || addr !== 32'h20 || req !== 1'b1) begin
      failures++;
      $display("FAIL redir_in_miss: got valid=%b miss=%b addr=%h req=%b, expected 0 0 20 1",
               valid, miss, addr, req);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || addr !== 32'h20 || valid !== 1'b0) begin
      failures++;
      $display("FAIL discard_wait: got miss=%b addr=%h valid=%b, expected 1 20 0", miss, addr, valid);
    end
    tick();
    ready = 1'b1; rdata = mem(32'h20);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || miss !== 1'b1 || instr !== 32'h0) begin
      failures++;
      $display("FAIL discard_drop: got valid=%b miss=%b instr=%h, expected 0 1 0", valid, miss, instr);
    end
    tick();
    hit(32'h40);
    @(negedge clk);
    checks++;
    if (addr !== 32'h40) begin
      failures++;
      $display("FAIL discard_target: got addr=%h, expected 40", addr);
    end
    tick();
    // Newest redirect target wins while the wrong-path response is outstanding.
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80;
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || addr !== 32'h44) begin
      failures++;
      $display("FAIL discard_rerdir: got miss=%b addr=%h, expected 1 44", miss, addr);
    end
    tick();
    redirect = 1'b0; ready = 1'b1; rdata = mem(32'h44);
    tick();
    hit(32'h80);
    @(negedge clk);
    checks++;
    if (addr !== 32'h80) begin
      failures++;
      $display("FAIL discard_newest: got addr=%h, expected 80", addr);
    end
    tick();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    ready = 1'b1; redirect_pc = 32'h300; rdata = mem(32'h84);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL discard_ready_redir: got valid=%b, expected 0", valid);
    end
    tick();
    redirect = 1'b0;
    hit(32'h300);
    @(negedge clk);
    checks++;
    if (addr !== 32'h300) begin
      failures++;
      $display("FAIL discard_same_cycle: got addr=%h, expected 300", addr);
    end
    tick();
  endtask

  task automatic test_redirect_hit();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103; rdata = mem(32'h304);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL redir_hit_drop: got valid=%b instr=%h, expected 0 0", valid, instr);
    end
    tick();
    redirect = 1'b0;
    hit(32'h100);
    @(negedge clk);
    checks++;
    if (addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_hit_target: got addr=%h, expected 100", addr);
    end
    tick();
    // Redirect beats a held stall; also exercises PC wrap at the top of memory.
    ready = 1'b1; stall = 1'b1; rdata = mem(32'h104);
    tick();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || instr !== mem(32'h104) || req !== 1'b0) begin
      failures++;
      $display("FAIL hold_redir: got valid=%b instr=%h req=%b, expected 1 %h 0",
               valid, instr, req, mem(32'h104));
    end
    tick();
    stall = 1'b0; redirect = 1'b0;
    hit(32'hFFFF_FFFC);
    @(negedge clk);
    checks++;
    if (addr !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap: got addr=%h pc4=%h, expected fffffffc 0", addr, pc4);
    end
    tick();
    hit(32'h0);
    @(negedge clk);
    checks++;
    if (addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: got addr=%h, expected 0", addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_miss();
    ready = 1'b0; rdata = 32'hBAD0_0002;
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || addr !== 32'h4) begin
      failures++;
      $display("FAIL pre_reset_miss: got miss=%b addr=%h, expected 1 4", miss, addr);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || miss !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_miss: got req=%b miss=%b valid=%b, expected 0 0 0", req, miss, valid);
    end
    tick();
    rst = 1'b0;
    hit(32'h0);
    @(negedge clk);
    checks++;
    if (pc_f !== 32'h0 || req !== 1'b1) begin
      failures++;
      $display("FAIL reset_resume: got pc=%h req=%b, expected 0 1", pc_f, req);
    end
    tick();
    hit(32'h4);
    @(negedge clk);
    checks++;
    if (addr !== 32'h4) begin
      failures++;
      $display("FAIL reset_resume_next: got addr=%h, expected 4", addr);
    end
    tick();
    ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_hits();
    test_miss();
    test_stall_hold();
    test_redirect_discard();
    test_redirect_hit();
    test_reset_mid_miss();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d unretired instructions, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
